// File: rtl/alu_operand_stage.sv
// Operand-select stage between decode and EX: picks A/B sources, resolves RAW hazards, registers operands.
// Build option: define OPERAND_FWD_EN to forward EX/MEM results; otherwise any EX/MEM hit stalls.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] pc,
    input  logic [1:0]        sel_a,
    input  logic [1:0]        sel_b,
    input  logic              imm_sext,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wen,
    input  logic [4:0]        mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_port,
    output logic [DATA_W-1:0] b_port,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned IMM_W = 16;
    localparam int unsigned EXT_W = DATA_W - IMM_W;

    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic              ex_hit_rs;
    logic              ex_hit_rt;
    logic              mem_hit_rs;
    logic              mem_hit_rt;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_val;
    logic [DATA_W-1:0] sa_val;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              unused_ok;

    assign rs_addr = instruction[25:21];
    assign rt_addr = instruction[20:16];
    assign rs_used = (sel_a == 2'b00) || (sel_a == 2'b11);
    assign rt_used = (sel_a == 2'b10) || (sel_b == 2'b10);

    // Register 0 is hardwired, so it never matches a producer.
    assign ex_hit_rs  = rs_used && ex_wen  && (ex_waddr  == rs_addr) && (rs_addr != 5'd0);
    assign ex_hit_rt  = rt_used && ex_wen  && (ex_waddr  == rt_addr) && (rt_addr != 5'd0);
    assign mem_hit_rs = rs_used && mem_wen && (mem_waddr == rs_addr) && (rs_addr != 5'd0);
    assign mem_hit_rt = rt_used && mem_wen && (mem_waddr == rt_addr) && (rt_addr != 5'd0);

`ifdef OPERAND_FWD_EN
    // Youngest producer wins; only a load still in EX cannot be bypassed.
    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
        if (ex_hit_rs)       rs_val = ex_wdata;
        else if (mem_hit_rs) rs_val = mem_wdata;
        if (ex_hit_rt)       rt_val = ex_wdata;
        else if (mem_hit_rt) rt_val = mem_wdata;
    end

    assign hazard    = ex_is_load && (ex_hit_rs || ex_hit_rt);
    assign unused_ok = ^instruction[31:26];
`else
    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
    end

    assign hazard    = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
    assign unused_ok = ^{instruction[31:26], ex_wdata, mem_wdata, ex_is_load};
`endif

    assign imm_val = imm_sext ? {{EXT_W{instruction[15]}}, instruction[15:0]}
                              : {{EXT_W{1'b0}}, instruction[15:0]};
    assign sa_val  = DATA_W'(instruction[10:6]);

    always_comb begin
        a_sel = rs_val;
        case (sel_a)
            2'b01:   a_sel = pc;
            2'b10:   a_sel = rt_val;
            default: a_sel = rs_val;
        endcase
    end

    always_comb begin
        b_sel = imm_val;
        case (sel_b)
            2'b01:   b_sel = sa_val;
            2'b10:   b_sel = rt_val;
            2'b11:   b_sel = DATA_W'(32'd4);
            default: b_sel = imm_val;
        endcase
    end

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Output register slice: load on accept, drop valid when consumed with nothing new.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            a_port    <= '0;
            b_port    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            a_port    <= a_sel;
            b_port    <= b_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating hazard-stall counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (in_valid && hazard && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reference model predicts operands and handshake,
// expected operand pairs are queued on accept and compared when the DUT presents them.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] rs_data, rt_data, pc;
    logic [1:0]  sel_a, sel_b;
    logic        imm_sext;
    logic        ex_wen, ex_is_load;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        mem_wen;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] a_port, b_port;
    logic [15:0] stall_cycles;
    logic        in_ready4, out_valid4;
    logic [31:0] a_port4, b_port4;
    logic [3:0]  stall_cycles4;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic        m_ov;
    logic [31:0] m_a, m_b;
    logic [15:0] m_stall;
    logic [3:0]  m_stall4;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
        .sel_a(sel_a), .sel_b(sel_b), .imm_sext(imm_sext),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .a_port(a_port), .b_port(b_port),
        .stall_cycles(stall_cycles)
    );

    alu_operand_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready4),
        .instruction(instruction), .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
        .sel_a(sel_a), .sel_b(sel_b), .imm_sext(imm_sext),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid4), .out_ready(out_ready), .a_port(a_port4), .b_port(b_port4),
        .stall_cycles(stall_cycles4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value a used source register should deliver.
    function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] rf);
`ifdef OPERAND_FWD_EN
        if (r != 5'd0 && ex_wen && ex_waddr == r)   return ex_wdata;
        if (r != 5'd0 && mem_wen && mem_waddr == r) return mem_wdata;
`endif
        return rf;
    endfunction

    function automatic logic src_hz(input logic [4:0] r);
        logic ex_m, mem_m;
        ex_m  = (r != 5'd0) && ex_wen && (ex_waddr == r);
        mem_m = (r != 5'd0) && mem_wen && (mem_waddr == r);
`ifdef OPERAND_FWD_EN
        return ex_m && ex_is_load;
`else
        return ex_m || mem_m;
`endif
    endfunction

    function automatic logic model_hazard();
        logic [4:0] rs, rt;
        rs = instruction[25:21];
        rt = instruction[20:16];
        return ((sel_a == 2'b00 || sel_a == 2'b11) && src_hz(rs)) ||
               ((sel_a == 2'b10 || sel_b == 2'b10) && src_hz(rt));
    endfunction

    function automatic logic [63:0] model_ops();
        logic [31:0] a, b;
        case (sel_a)
            2'b01:   a = pc;
            2'b10:   a = src_val(instruction[20:16], rt_data);
            default: a = src_val(instruction[25:21], rs_data);
        endcase
        case (sel_b)
            2'b00:   b = imm_sext ? {{16{instruction[15]}}, instruction[15:0]} : {16'h0, instruction[15:0]};
            2'b01:   b = {27'h0, instruction[10:6]};
            2'b10:   b = src_val(instruction[20:16], rt_data);
            default: b = 32'd4;
        endcase
        return {a, b};
    endfunction

    task automatic set_instr(input logic [1:0] sa, input logic [1:0] sb, input logic sx,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        sel_a = sa; sel_b = sb; imm_sext = sx;
        instruction = {6'h23, rs, rt, imm};
    endtask

    task automatic set_fwd(input logic ew, input logic el, input logic [4:0] ea, input logic [31:0] ed,
                           input logic mw, input logic [4:0] ma, input logic [31:0] md);
        ex_wen = ew; ex_is_load = el; ex_waddr = ea; ex_wdata = ed;
        mem_wen = mw; mem_waddr = ma; mem_wdata = md;
    endtask

    // One clock: predict ready, queue expected operands on accept, then compare registered outputs.
    task automatic step();
        logic hz, rdy, acc;
        logic [63:0] ops;
        #1;
        hz  = model_hazard();
        rdy = (!m_ov || out_ready) && !hz;
        check("in_ready", 64'(in_ready), 64'(rdy));
        acc = in_valid && rdy;
        if (acc) sb_q.push_back(model_ops());
        if (in_valid && hz) begin
            if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (m_stall4 != 4'hF)    m_stall4 = m_stall4 + 4'd1;
        end
        @(posedge clk);
        if (acc) m_ov = 1'b1;
        else if (out_ready) m_ov = 1'b0;
        #1;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (acc) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                ops = sb_q.pop_front();
                m_a = ops[63:32];
                m_b = ops[31:0];
            end
        end
        if (m_ov) begin
            check("a_port", 64'(a_port), 64'(m_a));
            check("b_port", 64'(b_port), 64'(m_b));
        end
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        check("stall_cycles_w4", 64'(stall_cycles4), 64'(m_stall4));
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pc = 32'h0000_1000;
        rs_data = 32'hAAAA_0001; rt_data = 32'hBBBB_0002;
        set_instr(2'b00, 2'b00, 1'b0, 5'd1, 5'd2, 16'h0);
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        m_ov = 1'b0; m_a = '0; m_b = '0; m_stall = '0; m_stall4 = '0;

        // Reset state before any clock edge.
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_a_port", 64'(a_port), 64'd0);
        check("rst_b_port", 64'(b_port), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        // Load-use hazard on rt=7 for three cycles, then accept.
        in_valid = 1'b1;
        set_instr(2'b00, 2'b10, 1'b0, 5'd1, 5'd7, 16'h0);
        set_fwd(1'b1, 1'b1, 5'd7, 32'hDEAD_0007, 1'b0, 5'd0, 32'h0);
        repeat (3) step();
        check("load_use_stall_count", 64'(stall_cycles), 64'd3);
        ex_wen = 1'b0;
        step();

        // Immediate sign/zero extension, back-to-back accepts.
        set_instr(2'b01, 2'b00, 1'b1, 5'd3, 5'd4, 16'h8000);
        step();
        check("imm_sext", 64'(b_port), 64'hFFFF_8000);
        imm_sext = 1'b0;
        step();
        check("imm_zext", 64'(b_port), 64'h0000_8000);

        // Shift amount, constant 4, rt as A.
        set_instr(2'b10, 2'b01, 1'b0, 5'd3, 5'd4, 16'h07C5);
        step();
        set_instr(2'b11, 2'b11, 1'b1, 5'd9, 5'd4, 16'hFFFF);
        step();

        // EX and MEM both hit rs=5: EX value wins when forwarding, stall otherwise.
        set_instr(2'b00, 2'b00, 1'b0, 5'd5, 5'd6, 16'h0010);
        set_fwd(1'b1, 1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        step();
`ifdef OPERAND_FWD_EN
        check("fwd_ex_priority", 64'(a_port), 64'h11);
`endif
        set_fwd(1'b0, 1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        step();
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();

        // Register 0 never hits.
        set_instr(2'b00, 2'b10, 1'b0, 5'd0, 5'd0, 16'h0);
        set_fwd(1'b1, 1'b1, 5'd0, 32'h33, 1'b1, 5'd0, 32'h44);
        step();
        check("r0_no_fwd", 64'(a_port), 64'hAAAA_0001);

        // Back-pressure: operands held, no accept for four cycles.
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rs_data = 32'h1234_5678;
        set_instr(2'b00, 2'b00, 1'b1, 5'd8, 5'd2, 16'h7FFF);
        step();
        out_ready = 1'b0;
        rs_data = 32'h9999_9999;
        repeat (4) step();
        check("held_a_port", 64'(a_port), 64'h1234_5678);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();

        // Hazard without in_valid must not count.
        set_instr(2'b00, 2'b00, 1'b0, 5'd12, 5'd2, 16'h0);
        set_fwd(1'b1, 1'b1, 5'd12, 32'h0, 1'b0, 5'd0, 32'h0);
        step();

        // Twenty hazard cycles saturate the narrow counter.
        in_valid = 1'b1;
        repeat (20) step();
        check("stall_sat_w4", 64'(stall_cycles4), 64'hF);

        // Short randomized mix.
        for (int i = 0; i < 24; i++) begin
            rs_data = $urandom; rt_data = $urandom; pc = $urandom;
            set_instr(2'($urandom), 2'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 16'($urandom));
            set_fwd(1'($urandom), 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end

        // Asynchronous reset while operands are held.
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_instr(2'b01, 2'b11, 1'b0, 5'd1, 5'd2, 16'h0);
        pc = 32'hCAFE_F00D;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_a", 64'(a_port), 64'd0);
        check("async_rst_b", 64'(b_port), 64'd0);
        check("async_rst_stall", 64'(stall_cycles), 64'd0);
        #1 resetn = 1'b1;
        m_ov = 1'b0; m_a = '0; m_b = '0; m_stall = '0; m_stall4 = '0;
        sb_q.delete();
        in_valid = 1'b1;
        step();
        out_ready = 1'b1; in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand and data width; legal values are 32 or greater.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  decode stage presents an instruction.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 instruction  in  32  raw instruction word.
REQ-008 rs_data, rt_data  in  DATA_W each  register-file read data.
REQ-009 pc  in  DATA_W  instruction address.
REQ-010 sel_a  in  2  A source: 00 rs, 01 pc, 10 rt, 11 rs.
REQ-011 sel_b  in  2  B source: 00 imm, 01 sa, 10 rt, 11 constant 4.
REQ-012 imm_sext  in  1  1 sign-extends imm, 0 zero-extends imm.
REQ-013 ex_wen, ex_is_load  in  1 each  EX-stage writeback enable, and EX-stage load flag.
REQ-014 ex_waddr  in  5  EX-stage destination register.
REQ-015 ex_wdata  in  DATA_W  EX-stage result.
REQ-016 mem_wen  in  1  MEM-stage writeback enable.
REQ-017 mem_waddr  in  5  MEM-stage destination register.
REQ-018 mem_wdata  in  DATA_W  MEM-stage result.
REQ-019 out_valid  out  1  registered operands are valid.
REQ-020 out_ready  in  1  EX stage consumes the operands.
REQ-021 a_port, b_port  out  DATA_W each  registered operands.
REQ-022 stall_cycles  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-023 rs is instruction[25:21] and rt is instruction[20:16]; rs is "used" when sel_a is 00 or 11; rt is "used" when sel_a is 10 or sel_b is 10.
REQ-024 The imm operand is instruction[15:0] extended to DATA_W according to imm_sext; sa is instruction[10:6] zero-extended; the constant is 4 zero-extended.
REQ-025 A hit is defined as wen=1, waddr=a used source, and waddr!=0; register 0 is never forwarded and never causes a stall.
REQ-026 Forwarding priority for each used source is: EX hit (ex_wdata), then MEM hit (mem_wdata), then register-file data.
REQ-027 A load-use hazard exists when an EX hit occurs with ex_is_load=1.
REQ-028 in_ready = (!out_valid || out_ready) && !hazard; this signal is combinational.
REQ-029 On in_valid && in_ready, a_port and b_port capture the selected operands and out_valid is set to 1 in the next cycle; latency is 1 cycle.
REQ-030 When out_valid && out_ready and no new accept occurs, out_valid clears to 0; simultaneous consume and accept keeps out_valid at 1 and loads the new operands.
REQ-031 While out_valid && !out_ready, a_port and b_port hold stable.
REQ-032 stall_cycles increments by 1 in each cycle where in_valid && hazard; it saturates at all-ones and does not wrap.
REQ-033 Inputs without in_valid never alter state, except the reset.

Reset
REQ-034 resetn low immediately forces out_valid=0, a_port=0, b_port=0, and stall_cycles=0, regardless of clk.
REQ-035 Reset asserted mid-transfer discards the held operands; the first accept after release behaves as from idle.

Configuration
REQ-036 Macro OPERAND_FWD_EN defined: forwarding is performed per REQ-026, and only REQ-027 stalls.
REQ-037 Macro OPERAND_FWD_EN undefined: there is no forwarding, operands come from the register file only, and any EX hit or MEM hit is a hazard.

Verification
REQ-038 Directed test: sel_b=00, imm_sext=1, instruction[15:0]=16'h8000 -> b_port=32'hFFFF8000 one cycle after accept; with imm_sext=0 -> 32'h00008000.
REQ-039 Directed test: EX hit on rs=5 with ex_wdata=32'h11 and MEM hit on rs=5 with 32'h22, FWD_EN defined -> a_port=32'h11.
REQ-040 Directed test: ex_is_load=1 hit on rt=7 for 3 cycles with in_valid=1 -> in_ready=0 for 3 cycles, stall_cycles=3, then accept occurs.
REQ-041 Directed test: out_ready=0 for 4 cycles after accept -> out_valid=1, operands unchanged, and in_ready=0 throughout.
REQ-042 Directed test: CNT_W=4 with 20 hazard cycles -> stall_cycles=4'hF.
REQ-043 Directed test: resetn pulsed low between clock edges with out_valid=1 -> out_valid=0 and ports=0 before the next edge.
